// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at its centre
// and emits one-cycle strobes for a good byte (data_valid) or a low stop bit (frame_err).
module uart_rx #(
  parameter int CLKS_PER_BIT = 833
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] debug_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    r_sync;
  logic          w_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_err;

  // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rx};
  end

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            if (r_idx == 3'd7) r_state <= S_STOP;
            else               r_idx   <= r_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // A line held low after a bad stop bit must go high before a new start is accepted.
          r_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign frame_err   = r_err;
  assign busy        = (r_state != S_IDLE);
  assign debug_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance at 833 clocks/bit, one at 16 clocks/bit, with a
// scoreboard of expected strobes and a monitor per instance.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx16 = 1'b1;
  logic       rx833 = 1'b1;
  logic [7:0] data_out16, data_out833;
  logic       dv16, dv833, fe16, fe833, busy16, busy833;
  logic [2:0] st16, st833;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         start16 = 0;
  int         ev_cyc16 = 0;
  logic [7:0] last16 = 8'h00;
  logic [7:0] last833 = 8'h00;
  logic [8:0] exp_q16[$];
  logic [8:0] exp_q833[$];
  logic [8:0] e16, e833;

  // Queue entries: bit 8 set means a frame_err strobe, otherwise data_valid with bits 7:0.
  localparam logic [8:0] EXP_FERR = 9'h100;

  uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .rst(rst), .rx(rx16),
    .data_out(data_out16), .data_valid(dv16), .frame_err(fe16),
    .busy(busy16), .debug_state(st16)
  );

  uart_rx #(.CLKS_PER_BIT(833)) u_dut833 (
    .clk(clk), .rst(rst), .rx(rx833),
    .data_out(data_out833), .data_valid(dv833), .frame_err(fe833),
    .busy(busy833), .debug_state(st833)
  );

  // Clock / reset
  always #10.4165 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx833 = v;
    else     rx16  = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_v, input int cpb);
    if (!sel) start16 = cyc;
    drive(sel, 1'b0, cpb);
    for (int k = 0; k < 8; k++) drive(sel, b[k], cpb);
    drive(sel, stop_v, cpb);
  endtask

  task automatic wait_drain(input bit sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sel ? (exp_q833.size() == 0) : (exp_q16.size() == 0)) break;
      @(negedge clk);
    end
    chk(sel ? "drain833" : "drain16", sel ? exp_q833.size() : exp_q16.size(), 0);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst && (dv16 || fe16)) begin
      ev_cyc16 = cyc;
      chk("excl16", dv16 & fe16, 1'b0);
      if (exp_q16.size() == 0) begin
        chk("unexpected16", {fe16, dv16, data_out16}, 10'h000);
      end else begin
        e16 = exp_q16.pop_front();
        if (e16[8]) begin
          chk("ferr16", {fe16, dv16}, 2'b10);
          chk("ferr16_hold", data_out16, last16);
        end else begin
          chk("valid16", {fe16, dv16}, 2'b01);
          chk("data16", data_out16, e16[7:0]);
          last16 = e16[7:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (dv833 || fe833)) begin
      chk("excl833", dv833 & fe833, 1'b0);
      if (exp_q833.size() == 0) begin
        chk("unexpected833", {fe833, dv833, data_out833}, 10'h000);
      end else begin
        e833 = exp_q833.pop_front();
        chk("valid833", {fe833, dv833}, e833[8] ? 2'b10 : 2'b01);
        if (!e833[8]) begin
          chk("data833", data_out833, e833[7:0]);
          last833 = e833[7:0];
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic busy_drop;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data16", data_out16, 8'h00);
    chk("rst_dv16", dv16, 1'b0);
    chk("rst_fe16", fe16, 1'b0);
    chk("rst_busy16", busy16, 1'b0);
    chk("rst_state16", st16, 3'd0);
    chk("rst_data833", data_out833, 8'h00);
    chk("rst_busy833", busy833, 1'b0);

    // Back-to-back 8'h00 frames at 833 clocks per bit.
    exp_q833.push_back(9'h000);
    exp_q833.push_back(9'h000);
    send_frame(1'b1, 8'h00, 1'b1, 833);
    send_frame(1'b1, 8'h00, 1'b1, 833);
    wait_drain(1'b1, 2000);
    chk("b2b_data833", data_out833, 8'h00);
    chk("b2b_idle833", busy833, 1'b0);

    // 8'hA5 at 16 clocks per bit: latency and busy.
    drive(1'b0, 1'b1, 16);
    exp_q16.push_back(9'h0A5);
    busy_drop = 1'b0;
    fork
      send_frame(1'b0, 8'hA5, 1'b1, 16);
      begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 151; i++) begin
          if (!busy16) busy_drop = 1'b1;
          @(negedge clk);
        end
      end
    join
    wait_drain(1'b0, 200);
    chk("busy_throughout", busy_drop, 1'b0);
    // 2 synchroniser cycles + 1 + HALF(8) + 9*16 = 155 cycles from the pin falling.
    chk("latency16", ev_cyc16 - start16, 155);
    chk("busy_after16", busy16, 1'b0);

    // Start-bit glitch of HALF/2 = 4 cycles.
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 48);
    chk("glitch_data16", data_out16, 8'hA5);
    chk("glitch_state16", st16, 3'd0);
    chk("glitch_busy16", busy16, 1'b0);

    // 8'h3C with a low stop bit, line held low three more bits, then 8'h81.
    exp_q16.push_back(EXP_FERR);
    send_frame(1'b0, 8'h3C, 1'b0, 16);
    drive(1'b0, 1'b0, 48);
    chk("break_state16", st16, 3'd4);
    chk("break_busy16", busy16, 1'b1);
    wait_drain(1'b0, 10);
    drive(1'b0, 1'b1, 16);
    chk("break_exit16", st16, 3'd0);
    exp_q16.push_back(9'h081);
    send_frame(1'b0, 8'h81, 1'b1, 16);
    wait_drain(1'b0, 200);
    chk("after_break16", data_out16, 8'h81);

    // Reset during data bit 4 of 8'hFF, then 8'h5A.
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b1, 4 * 16 + 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last16 = 8'h00;
    chk("midrst_data16", data_out16, 8'h00);
    chk("midrst_dv16", dv16, 1'b0);
    chk("midrst_fe16", fe16, 1'b0);
    chk("midrst_busy16", busy16, 1'b0);
    chk("midrst_state16", st16, 3'd0);
    drive(1'b0, 1'b1, 8 + 3 * 16 + 32);
    chk("midrst_quiet16", data_out16, 8'h00);
    exp_q16.push_back(9'h05A);
    send_frame(1'b0, 8'h5A, 1'b1, 16);
    wait_drain(1'b0, 200);
    chk("final_data16", data_out16, 8'h5A);

    drive(1'b0, 1'b1, 32);
    chk("q16_empty", exp_q16.size(), 0);
    chk("q833_empty", exp_q833.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
